// File: rtl/store_align_unit.sv
// Store-path aligner: narrows rt to byte/half/word, builds strobes, flags AdES, and
// queues aligned stores in a small FIFO that drains over a req/addr_ok/data_ok bus.
module store_align_unit #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [1:0]    st_size,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_wdata,
    output logic          ades,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [3:0]    data_wstrb,
    output logic [31:0]   data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    output logic          busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t        r_state, w_state_nxt;

    logic [1:0]    r_size  [DEPTH];
    logic [AW-1:0] r_addr  [DEPTH];
    logic [3:0]    r_wstrb [DEPTH];
    logic [31:0]   r_wdata [DEPTH];

    logic [PW-1:0] r_wptr, r_rptr;
    logic [PW:0]   r_count;

    logic          w_full, w_empty, w_misalign, w_push, w_pop;
    logic [3:0]    w_fmt_wstrb;
    logic [31:0]   w_fmt_wdata;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign st_ready = ~w_full;

    always_comb begin
        w_misalign = 1'b0;
        unique case (st_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = st_addr[0];
            2'b10:   w_misalign = (st_addr[1:0] != 2'b00);
            default: w_misalign = 1'b1;
        endcase
    end

    assign ades   = st_valid & w_misalign;
    // Readiness comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign w_push = st_valid & ~w_full & ~w_misalign;
    assign w_pop  = (r_state == S_REQ) & data_addr_ok;

    always_comb begin
        w_fmt_wstrb = 4'hF;
        w_fmt_wdata = st_wdata;
        unique case (st_size)
            2'b00: begin
                w_fmt_wstrb = 4'b0001 << st_addr[1:0];
                w_fmt_wdata = {4{st_wdata[7:0]}};
            end
            2'b01: begin
                w_fmt_wstrb = st_addr[1] ? 4'b1100 : 4'b0011;
                w_fmt_wdata = {2{st_wdata[15:0]}};
            end
            default: begin
                w_fmt_wstrb = 4'hF;
                w_fmt_wdata = st_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_size[r_wptr]  <= st_size;
            r_addr[r_wptr]  <= st_addr;
            r_wstrb[r_wptr] <= w_fmt_wstrb;
            r_wdata[r_wptr] <= w_fmt_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // A push this cycle counts as non-empty so the request rises one cycle after the store.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (!w_empty || w_push) w_state_nxt = S_REQ;
            S_REQ:  if (data_addr_ok)       w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (data_data_ok) w_state_nxt = (!w_empty || w_push) ? S_REQ : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        data_req   = 1'b0;
        data_size  = '0;
        data_addr  = '0;
        data_wstrb = '0;
        data_wdata = '0;
        if (r_state == S_REQ) begin
            data_req   = 1'b1;
            data_size  = r_size[r_rptr];
            data_addr  = r_addr[r_rptr];
            data_wstrb = r_wstrb[r_rptr];
            data_wdata = r_wdata[r_rptr];
        end
    end

    assign data_wr = 1'b1;
    assign busy    = ~w_empty | (r_state != S_IDLE);

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: expected bus writes are queued when a store
// is offered and compared against the head presented when the bench grants addr_ok.
module tb_store_align_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic        ades;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        busy;

    typedef struct packed {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    store_align_unit #(.DEPTH(2), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size),
        .st_addr(st_addr), .st_wdata(st_wdata), .ades(ades),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            2'b10:   return a[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic exp_t model_fmt(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.size = sz;
        e.addr = a;
        case (sz)
            2'b00: begin
                e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
                e.wstrb = (a[1:0] == 2'd0) ? 4'b0001 : (a[1:0] == 2'd1) ? 4'b0010 :
                          (a[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
            end
            2'b01: begin
                e.wdata = {d[15:0], d[15:0]};
                e.wstrb = a[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                e.wdata = d;
                e.wstrb = 4'b1111;
            end
        endcase
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         input bit exp_acc);
        st_valid = 1'b1;
        st_size  = sz;
        st_addr  = a;
        st_wdata = d;
        #1;
        chk("ades", ades, model_mis(sz, a));
        if (exp_acc) sb.push_back(model_fmt(sz, a, d));
    endtask

    task automatic accept(input string tag);
        exp_t e;
        chk({tag, "_req"}, data_req, 1'b1);
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_size"},  data_size,  e.size);
            chk({tag, "_addr"},  data_addr,  e.addr);
            chk({tag, "_wstrb"}, data_wstrb, e.wstrb);
            chk({tag, "_wdata"}, data_wdata, e.wdata);
        end
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #1;
    endtask

    task automatic complete();
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_size = '0; st_addr = '0; st_wdata = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_req",   data_req,   1'b0);
        chk("rst_busy",  busy,       1'b0);
        chk("rst_ready", st_ready,   1'b1);
        chk("rst_wr",    data_wr,    1'b1);
        chk("rst_size",  data_size,  2'b00);
        chk("rst_addr",  data_addr,  32'h0);
        chk("rst_wstrb", data_wstrb, 4'h0);
        chk("rst_wdata", data_wdata, 32'h0);

        // SB to the top byte lane
        offer(2'b00, 32'h0000_1003, 32'h1234_56AB, 1'b1);
        chk("sb_ades", ades, 1'b0);
        tick();
        st_valid = 1'b0;
        chk("sb_wstrb", data_wstrb, 4'b1000);
        chk("sb_wdata", data_wdata, 32'hABAB_ABAB);
        accept("sb");
        chk("sb_wait_req",  data_req, 1'b0);
        chk("sb_wait_busy", busy,     1'b1);
        complete();
        chk("sb_idle_busy", busy, 1'b0);

        // misaligned stores: flagged same cycle, never queued
        offer(2'b01, 32'h0000_2001, 32'h0000_5555, 1'b0);
        chk("sh_ades", ades, 1'b1);
        tick();
        st_valid = 1'b0;
        chk("sh_req",  data_req, 1'b0);
        chk("sh_busy", busy,     1'b0);
        offer(2'b10, 32'h0000_2002, 32'h0, 1'b0);
        offer(2'b11, 32'h0000_2000, 32'h0, 1'b0);
        offer(2'b01, 32'h0000_2002, 32'h0000_BEEF, 1'b0);
        chk("sh_ok_ades", ades, 1'b0);
        st_valid = 1'b0;
        #1;
        tick();
        chk("mis_req", data_req, 1'b0);

        // SW with addr_ok withheld for three cycles
        offer(2'b10, 32'h0000_3000, 32'hDEAD_BEEF, 1'b1);
        tick();
        st_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("sw_hold_req",   data_req,   1'b1);
            chk("sw_hold_addr",  data_addr,  32'h0000_3000);
            chk("sw_hold_wdata", data_wdata, 32'hDEAD_BEEF);
            chk("sw_hold_wstrb", data_wstrb, 4'hF);
            tick();
        end
        accept("sw");
        for (int i = 0; i < 2; i++) begin
            chk("sw_wait_req",  data_req, 1'b0);
            chk("sw_wait_busy", busy,     1'b1);
            tick();
        end
        complete();
        chk("sw_done_busy", busy, 1'b0);

        // fill the FIFO, stall a third store, drain in order
        offer(2'b01, 32'h0000_4002, 32'h0000_CAFE, 1'b1);
        tick();
        chk("fill_ready1", st_ready, 1'b1);
        offer(2'b10, 32'h0000_5004, 32'h0102_0304, 1'b1);
        tick();
        chk("fill_full", st_ready, 1'b0);
        offer(2'b00, 32'h0000_6001, 32'h0000_0077, 1'b0);
        tick();
        chk("fill_stall", st_ready, 1'b0);
        accept("fifo_a");
        chk("fill_ready_pop", st_ready, 1'b1);
        offer(2'b00, 32'h0000_6001, 32'h0000_0077, 1'b1);
        complete();
        st_valid = 1'b0;
        chk("fill_full2", st_ready, 1'b0);
        accept("fifo_b");
        complete();
        accept("fifo_c");
        complete();
        chk("fill_busy", busy, 1'b0);

        // push and pop in the same cycle with one entry queued
        offer(2'b10, 32'h0000_7000, 32'h1111_1111, 1'b1);
        tick();
        st_valid = 1'b0;
        offer(2'b10, 32'h0000_7010, 32'h2222_2222, 1'b1);
        accept("pp_d");
        st_valid = 1'b0;
        chk("pp_ready", st_ready, 1'b1);
        chk("pp_busy",  busy,     1'b1);
        chk("pp_req",   data_req, 1'b0);
        offer(2'b00, 32'h0000_7022, 32'h0000_0033, 1'b1);
        tick();
        st_valid = 1'b0;
        chk("pp_cnt2", st_ready, 1'b0);
        complete();
        accept("pp_e");
        complete();
        accept("pp_f");
        complete();
        chk("pp_busy_end", busy, 1'b0);

        // reset while a write is outstanding and two entries queued
        offer(2'b10, 32'h0000_8000, 32'hAAAA_0000, 1'b1);
        tick();
        st_valid = 1'b0;
        offer(2'b10, 32'h0000_8004, 32'hBBBB_0000, 1'b1);
        accept("rs_g");
        st_valid = 1'b0;
        offer(2'b10, 32'h0000_8008, 32'hCCCC_0000, 1'b1);
        tick();
        st_valid = 1'b0;
        chk("rs_pre_full", st_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_req",   data_req,  1'b0);
        chk("rs_busy",  busy,      1'b0);
        chk("rs_ready", st_ready,  1'b1);
        chk("rs_addr",  data_addr, 32'h0);
        sb.delete();
        complete();
        chk("rs_late_ok_busy", busy,     1'b0);
        chk("rs_late_ok_req",  data_req, 1'b0);
        tick();
        chk("rs_no_reissue", data_req, 1'b0);

        offer(2'b00, 32'h0000_9002, 32'h0000_00C4, 1'b1);
        tick();
        st_valid = 1'b0;
        accept("post_rst");
        complete();
        chk("end_busy", busy, 1'b0);
        chk("end_sb", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
